systolic_result_drain: RTL and testbench

Drain controller and result reader for the 4x4 systolic array. After a matrix computation, it shifts the accumulated partial sums out of the array's bottom edge, one row per cycle. It captures them into a reorder buffer and presents them row 0 first on a valid/ready stream for the downstream writeback logic. It sits between the array's `ps_bottom_out_flat` / `en_shift_bottom` pins and the result sink.

---
 rtl/systolic_pkg.sv | 15 +
 rtl/systolic_result_drain.sv | 88 ++++++++
 tb/tb_systolic_result_drain.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array result path.
package systolic_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned N      = 4;
  // One packed row of partial sums, column c at [c*DATA_W +: DATA_W].
  localparam int unsigned ROW_W  = N * DATA_W;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StSend  = 2'd2
  } drain_state_t;

endpackage

// File: rtl/systolic_result_drain.sv
// Drains the systolic array's bottom edge into a row buffer, then streams the
// rows out in row order (row 0 first) on a valid/ready interface.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = systolic_pkg::DATA_W,
  parameter int unsigned N      = systolic_pkg::N,
  localparam int unsigned RowW  = N * DATA_W,
  localparam int unsigned CntW  = $clog2(N)
) (
  input  logic            Clock,
  input  logic            rst,
  input  logic            start,
  input  logic [RowW-1:0] ps_bottom_in,
  output logic            en_shift_bottom,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RowW-1:0] out_data,
  output logic [CntW-1:0] out_row,
  output logic            out_last,
  output logic            done
);

  localparam logic [CntW-1:0] LastIdx = CntW'(N - 1);

  drain_state_t    r_state;
  logic [CntW-1:0] r_dcnt;
  logic [CntW-1:0] r_scnt;
  logic            r_done;
  logic [RowW-1:0] r_buf [N];

  // Controller: state, drain/send counters, row buffer and done pulse.
  always_ff @(posedge Clock or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_dcnt  <= '0;
      r_scnt  <= '0;
      r_done  <= 1'b0;
      r_buf   <= '{default: '0};
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state <= StDrain;
            r_dcnt  <= '0;
          end
        end
        StDrain: begin
          // The bottom edge shows the pre-shift value, so the deepest row
          // arrives first and fills the buffer from the top index down.
          r_buf[LastIdx - r_dcnt] <= ps_bottom_in;
          if (r_dcnt == LastIdx) begin
            r_state <= StSend;
            r_scnt  <= '0;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        StSend: begin
          if (out_ready) begin
            if (r_scnt == LastIdx) begin
              r_state <= StIdle;
              r_scnt  <= '0;
              r_done  <= 1'b1;
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Outputs are decoded from registers only; nothing depends on start.
  always_comb begin
    en_shift_bottom = (r_state == StDrain);
    busy            = (r_state != StIdle);
    out_valid       = (r_state == StSend);
    out_data        = r_buf[r_scnt];
    out_row         = r_scnt;
    out_last        = (r_state == StSend) && (r_scnt == LastIdx);
    done            = r_done;
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: models the array's bottom-edge shift and
// checks the result stream against a queue of expected rows.
`timescale 1ns/1ps
module tb_systolic_result_drain;

  localparam int DW = 16;
  localparam int NN = 4;
  localparam int RW = NN * DW;

  logic          Clock = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [RW-1:0] ps_bottom_in;
  logic [RW-1:0] out_data;
  logic [1:0]    out_row;
  logic          en_shift_bottom, busy, out_valid, out_last, done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_start = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  systolic_result_drain #(
    .DATA_W(DW),
    .N     (NN)
  ) dut (
    .Clock          (Clock),
    .rst            (rst),
    .start          (start),
    .ps_bottom_in   (ps_bottom_in),
    .en_shift_bottom(en_shift_bottom),
    .busy           (busy),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_row        (out_row),
    .out_last       (out_last),
    .done           (done)
  );

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Element (r,c) = 16'h0r0c.
  function automatic logic [RW-1:0] pat_row(input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int c = 0; c < NN; c++) v[c*DW +: DW] = {8'(r), 8'(c)};
    return v;
  endfunction

  // Array model: rows move down one per shift, zeros enter at the top.
  logic [RW-1:0] arr [NN];
  int load_seq = 0;
  int seen_seq = 0;
  bit load_ones = 1'b0;

  always @(posedge Clock) begin
    if (load_seq != seen_seq) begin
      seen_seq <= load_seq;
      for (int r = 0; r < NN; r++) arr[r] <= load_ones ? '1 : pat_row(r);
    end else if (en_shift_bottom) begin
      for (int r = NN - 1; r > 0; r--) arr[r] <= arr[r-1];
      arr[0] <= '0;
    end
  end
  assign ps_bottom_in = arr[NN-1];

  // Expected-result model and per-cycle compare.
  logic [RW-1:0] exp_q [$];
  logic [RW-1:0] obs_q [$];
  logic [RW-1:0] prev_data;
  int exp_idx = 0;
  bit exp_done_next = 1'b0;
  bit stalled_prev = 1'b0;
  bit chk_en = 1'b0;
  int en_cnt = 0;
  int done_cnt = 0;

  always @(negedge Clock) begin
    if (rst) begin
      stalled_prev  = 1'b0;
      exp_done_next = 1'b0;
    end else if (chk_en) begin
      check("done_pulse", RW'(done), RW'(exp_done_next));
      exp_done_next = 1'b0;
      check("done_and_valid", RW'(done && out_valid), '0);
      if (done) done_cnt++;
      if (en_shift_bottom) en_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_row: got row %0d data %h, expected no row", out_row, out_data);
        end else begin
          check("row_data", out_data, exp_q[0]);
          check("row_index", RW'(out_row), RW'(exp_idx));
          check("row_last", RW'(out_last), RW'(exp_idx == NN - 1));
          if (stalled_prev) check("stall_hold", out_data, prev_data);
          if (out_ready) begin
            obs_q.push_back(out_data);
            void'(exp_q.pop_front());
            exp_idx++;
            if (exp_idx == NN) begin
              exp_idx = 0;
              exp_done_next = 1'b1;
            end
          end
        end
        stalled_prev = !out_ready;
        prev_data    = out_data;
      end else begin
        stalled_prev = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input bit ones);
    load_ones = ones;
    load_seq++;
    tick();
  endtask

  task automatic pulse_start(input bit accepted);
    if (accepted) begin
      for (int r = 0; r < NN; r++) exp_q.push_back(arr[r]);
      t_start = cyc;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (done) begin
        lat = cyc - t_start;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got no done within 200 cycles, expected done", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int lat2;
    int k;

    // Reset and idle
    tick();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk_en = 1'b1;
    load(1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("idle_en_pulses", RW'(en_cnt), '0);
    check("idle_busy", RW'(busy), '0);
    check("idle_valid", RW'(out_valid), '0);
    check("idle_data", out_data, '0);
    check("idle_row", RW'(out_row), '0);
    check("idle_last", RW'(out_last), '0);
    check("idle_done", RW'(done), '0);

    // Basic drain with ready held high
    en_cnt = 0;
    obs_q.delete();
    pulse_start(1'b1);
    check("busy_after_start", RW'(busy), RW'(1));
    check("shift_after_start", RW'(en_shift_bottom), RW'(1));
    wait_done("basic_done", lat);
    check("basic_latency", RW'(lat), RW'(2 * NN + 1));
    check("basic_busy_at_done", RW'(busy), '0);
    check("basic_en_pulses", RW'(en_cnt), RW'(4));
    check("basic_rows", RW'(obs_q.size()), RW'(4));
    if (obs_q.size() == 4) begin
      check("basic_row0", obs_q[0], 64'h0003_0002_0001_0000);
      check("basic_row3", obs_q[3], 64'h0303_0302_0301_0300);
    end

    // Backpressure: ready 1,0,0,1,...
    load(1'b0);
    obs_q.delete();
    pulse_start(1'b1);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      k++;
      tick();
    end
    check("bp_done_seen", RW'(done), RW'(1));
    out_ready = 1'b1;
    check("bp_rows", RW'(obs_q.size()), RW'(4));
    if (obs_q.size() == 4) check("bp_row2", obs_q[2], 64'h0203_0202_0201_0200);

    // start pulses while busy are ignored
    tick();
    load(1'b0);
    en_cnt = 0;
    k = done_cnt;
    pulse_start(1'b1);
    tick();
    tick();
    pulse_start(1'b0);
    tick();
    pulse_start(1'b0);
    wait_done("ignore_done", lat);
    for (int i = 0; i < 12; i++) tick();
    check("ignore_done_count", RW'(done_cnt - k), RW'(1));
    check("ignore_en_pulses", RW'(en_cnt), RW'(4));

    // Reset on the 2nd SEND beat
    load(1'b0);
    pulse_start(1'b1);
    for (int i = 0; i < NN + 1; i++) tick();
    check("pre_reset_row", RW'(out_row), RW'(1));
    rst = 1'b1;
    #1;
    check("rst_valid", RW'(out_valid), '0);
    check("rst_busy", RW'(busy), '0);
    check("rst_shift", RW'(en_shift_bottom), '0);
    check("rst_data", out_data, '0);
    check("rst_row", RW'(out_row), '0);
    exp_q.delete();
    exp_idx = 0;
    tick();
    rst = 1'b0;
    tick();
    load(1'b1);
    obs_q.delete();
    pulse_start(1'b1);
    wait_done("ones_done", lat);
    check("ones_rows", RW'(obs_q.size()), RW'(4));
    for (int i = 0; i < NN && i < obs_q.size(); i++) check("ones_row", obs_q[i], '1);

    // Back-to-back drains; the second reads the zeros left by the first
    tick();
    load(1'b0);
    obs_q.delete();
    en_cnt = 0;
    pulse_start(1'b1);
    wait_done("b2b_first_done", lat);
    pulse_start(1'b1);
    wait_done("b2b_second_done", lat2);
    check("b2b_latency", RW'(lat2), RW'(2 * NN + 1));
    check("b2b_en_pulses", RW'(en_cnt), RW'(8));
    check("b2b_rows", RW'(obs_q.size()), RW'(8));
    for (int i = NN; i < 2 * NN && i < obs_q.size(); i++) check("b2b_zero_row", obs_q[i], '0);

    for (int i = 0; i < 4; i++) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
